// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the Z80 multi-source interrupt arbiter.
// Holds the FSM state encoding, register-select codes and parameter defaults.
package int_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2,
    HOLD   = 2'd3
  } int_state_t;

  localparam logic [1:0] INT_REG_MASK = 2'd0;
  localparam logic [1:0] INT_REG_PEND = 2'd1;
  localparam logic [1:0] INT_REG_CFG  = 2'd2;
  localparam logic [1:0] INT_REG_STAT = 2'd3;

  localparam int N_SRC_DEFAULT   = 4;
  localparam int INT_LEN_DEFAULT = 32;
  localparam int HOLDOFF_DEFAULT = 2;

  localparam logic [7:0] LEGACY_VECTOR = 8'hFF;

endpackage

// File: rtl/int_arbiter_prio_enc.sv
// Fixed-priority encoder: returns the lowest set request index plus a valid flag.
module int_prio_enc #(
  parameter int N_SRC = 4,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Maskable multi-source Z80 interrupt controller with IM2 vector supply.
// Legacy mode reproduces the old frame-only /INT generator with vector 0xFF.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEFAULT,
  parameter int INT_LEN = INT_LEN_DEFAULT,
  parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic             rst_n,
  input  logic             clkcpu,
  input  logic [N_SRC-1:0] src_stb,
  input  logic             inta,
  input  logic             reg_wr,
  input  logic [1:0]       reg_sel,
  input  logic [7:0]       reg_din,
  output logic [7:0]       reg_dout,
  output logic             n_int,
  output logic             vector_oe,
  output logic [7:0]       vector_data
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(INT_LEN + 1);
  localparam int HLD_W = $clog2(HOLDOFF + 1);

  localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(INT_LEN);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF - 1);

  int_state_t       state;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] mask;
  logic [4:0]       vbase;
  logic             legacy;
  logic [IDX_W-1:0] cur_src;
  logic [CNT_W-1:0] cnt;
  logic [HLD_W-1:0] hcnt;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] elig;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             acked;
  logic             timeout;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] tmo_clr;
  logic [1:0]       src2;
  logic [7:0]       vec_next;

  // A strobe arriving this cycle can already win, giving one-cycle strobe-to-/INT latency.
  always_comb begin
    req       = pend | src_stb;
    elig      = legacy ? (req & mask & ONE_HOT0) : (req & mask);
    acked     = (state == ASSERT) && inta;
    timeout   = (state == ASSERT) && !inta && (cnt == CNT_LAST);
    w1c_clr   = (reg_wr && (reg_sel == INT_REG_PEND)) ? reg_din[N_SRC-1:0] : '0;
    ack_clr   = acked ? (ONE_HOT0 << cur_src) : '0;
    tmo_clr   = timeout ? ONE_HOT0 : '0;
    pend_next = (pend & ~(w1c_clr | ack_clr | tmo_clr)) | src_stb;
    src2      = 2'(cur_src);
    vec_next  = legacy ? LEGACY_VECTOR : {vbase, src2, 1'b0};
  end

  int_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req   (elig),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    reg_dout = 8'h00;
    case (reg_sel)
      INT_REG_MASK: reg_dout = 8'(mask);
      INT_REG_PEND: reg_dout = 8'(pend);
      INT_REG_CFG:  reg_dout = {vbase, 2'b00, legacy};
      INT_REG_STAT: reg_dout = {(state != IDLE), 5'b00000, src2};
      default:      reg_dout = 8'h00;
    endcase
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= ONE_HOT0;
      vbase  <= 5'b11111;
      legacy <= 1'b1;
      pend   <= '0;
    end else begin
      pend <= pend_next;
      if (reg_wr && (reg_sel == INT_REG_MASK)) mask <= reg_din[N_SRC-1:0];
      if (reg_wr && (reg_sel == INT_REG_CFG)) begin
        vbase  <= reg_din[7:3];
        legacy <= reg_din[0];
      end
    end
  end

  // The vector is captured on entry to ACK so config writes cannot disturb it mid-cycle.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_int       <= 1'b1;
      vector_oe   <= 1'b0;
      vector_data <= LEGACY_VECTOR;
      cur_src     <= '0;
      cnt         <= '0;
      hcnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= ASSERT;
            n_int   <= 1'b0;
            cnt     <= '0;
            cur_src <= win_idx;
          end
        end
        ASSERT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (inta) begin
            state       <= ACK;
            n_int       <= 1'b1;
            vector_oe   <= 1'b1;
            vector_data <= vec_next;
          end else if (cnt == CNT_LAST) begin
            state <= HOLD;
            n_int <= 1'b1;
            hcnt  <= '0;
          end
        end
        ACK: begin
          n_int <= 1'b1;
          if (!inta) begin
            vector_oe <= 1'b0;
            state     <= HOLD;
            hcnt      <= '0;
          end
        end
        HOLD: begin
          n_int <= 1'b1;
          if (hcnt == HLD_LAST) state <= IDLE;
          else hcnt <= hcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
